duc_frame_pack: RTL and testbench

//  Downstream framer for the DUC output AXI-Stream (32b {I16,Q16}, tlast every 256 beats).

---
 rtl/duc_frame_pack.sv | 75 +++++++
 tb/tb_duc_frame_pack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/duc_frame_pack.sv
// duc_frame_pack: prepends a sync/seq header to each DUC AXI-Stream frame and enforces frame length
module duc_frame_pack #(
    parameter logic [31:0] SYNC_WORD = 32'hEB90_146F,
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic        axis_clk,
    input  logic        rst_n,
    input  logic        pack_en,
    input  logic        err_clr,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [15:0] frame_cnt,
    output logic        len_err
);
    typedef enum logic [1:0] {IDLE, HDR1, PAY, RESYNC} state_t;
    localparam logic [15:0] LEN = 16'(FRAME_LEN);
    localparam logic [15:0] LAST = 16'(FRAME_LEN - 1);
    state_t state;
    logic [15:0] cnt;
    logic adv, acc, at_end;
    assign adv = ~m_tvalid | m_tready;
    assign s_tready = state == PAY ? adv : state == RESYNC;
    assign acc = s_tvalid & s_tready;
    assign at_end = cnt == LAST;
    // seq and frame_cnt always advance together, so frame_cnt doubles as the header seq
    always_ff @(posedge axis_clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            m_tdata <= '0;
            m_tvalid <= 1'b0;
            m_tlast <= 1'b0;
            frame_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            if (adv) begin
                m_tvalid <= 1'b0;
                m_tlast <= 1'b0;
            end
            if (err_clr) len_err <= 1'b0;
            case (state)
                IDLE: if (pack_en & s_tvalid & adv) begin
                    m_tdata <= SYNC_WORD;
                    m_tvalid <= 1'b1;
                    state <= HDR1;
                end
                HDR1: if (adv) begin
                    m_tdata <= {frame_cnt, LEN};
                    m_tvalid <= 1'b1;
                    cnt <= '0;
                    state <= PAY;
                end
                PAY: if (acc) begin
                    m_tdata <= s_tdata;
                    m_tvalid <= 1'b1;
                    cnt <= cnt + 16'd1;
                    if (s_tlast | at_end) begin
                        m_tlast <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state <= s_tlast ? IDLE : RESYNC;
                    end
                    if (s_tlast != at_end) len_err <= 1'b1;
                end
                RESYNC: if (acc & s_tlast) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_duc_frame_pack.sv
// tb_duc_frame_pack: scoreboard bench for duc_frame_pack framing, backpressure, length errors and reset
module tb_duc_frame_pack;
    localparam logic [31:0] SYNC = 32'hEB90146F;
    logic axis_clk = 0, rst_n = 0, pack_en = 0, err_clr = 0;
    logic [31:0] s_tdata = 0;
    logic s_tvalid = 0, s_tlast = 0, s_tready;
    logic [31:0] m_tdata;
    logic m_tvalid, m_tlast;
    logic m_tready = 1;
    logic [15:0] frame_cnt;
    logic len_err;
    int checks = 0, failures = 0;
    logic [32:0] q[$];
    bit rnd = 0, mon_en = 1;
    logic [15:0] exp_seq = 0;

    duc_frame_pack dut (
        .axis_clk(axis_clk), .rst_n(rst_n), .pack_en(pack_en), .err_clr(err_clr),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .frame_cnt(frame_cnt), .len_err(len_err)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge axis_clk);
        #1 m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: pops the scoreboard on every output transfer and checks stall stability
    initial begin
        logic [31:0] pd;
        logic pl, pv;
        logic [32:0] e;
        pv = 0;
        pd = 0;
        pl = 0;
        forever begin
            @(negedge axis_clk);
            if (rst_n && mon_en) begin
                if (pv) begin
                    chk("stall_data", m_tdata, pd);
                    chk("stall_flags", {30'd0, m_tvalid, m_tlast}, {30'd0, 1'b1, pl});
                end
                if (m_tvalid && m_tready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%h expected=none", m_tdata);
                    end else begin
                        e = q.pop_front();
                        chk("beat_data", m_tdata, e[31:0]);
                        chk("beat_last", {31'd0, m_tlast}, {31'd0, e[32]});
                    end
                end
                pv = m_tvalid && !m_tready;
                pd = m_tdata;
                pl = m_tlast;
            end else pv = 0;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l);
        s_tdata = d;
        s_tlast = l;
        s_tvalid = 1;
        for (int t = 0; ; t++) begin
            @(negedge axis_clk);
            if (s_tready) break;
            if (t > 2000) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=stalled required=accepted");
                break;
            end
        end
        @(posedge axis_clk);
        #1 s_tvalid = 0;
        s_tlast = 0;
    endtask

    task automatic send_frame(input int n, input int tl, input logic [15:0] tag, input bit push,
                              input int en_off, input bit clr_last);
        int np;
        np = (tl >= 0 && tl < 256) ? tl + 1 : 256;
        if (push) begin
            q.push_back({1'b0, SYNC});
            q.push_back({1'b0, exp_seq, 16'h0100});
            for (int i = 0; i < np; i++) q.push_back({i == np - 1, tag, 16'(i)});
            exp_seq++;
        end
        for (int i = 0; i < n; i++) begin
            if (i == en_off) pack_en = 0;
            err_clr = clr_last && i == tl;
            send_beat({tag, 16'(i)}, i == tl);
        end
        err_clr = 0;
    endtask

    task automatic drain();
        for (int t = 0; q.size() != 0; t++) begin
            @(posedge axis_clk);
            if (t > 5000) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout actual=%0d required=0", q.size());
                q.delete();
            end
        end
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
    endtask

    initial begin
        pack_en = 1;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("reset_mdata", m_tdata, 0);
        chk("reset_flags", {28'd0, m_tvalid, m_tlast, s_tready, len_err}, 0);
        chk("reset_fcnt", {16'd0, frame_cnt}, 0);
        @(posedge axis_clk);
        #1 rst_n = 1;
        // nominal frames
        send_frame(256, 255, 16'h0001, 1, -1, 0);
        drain();
        chk("fcnt_after_1", {16'd0, frame_cnt}, 1);
        send_frame(256, 255, 16'h0002, 1, -1, 0);
        drain();
        chk("fcnt_after_2", {16'd0, frame_cnt}, 2);
        chk("no_err_nominal", {31'd0, len_err}, 0);
        // random backpressure
        rnd = 1;
        for (int f = 0; f < 3; f++) send_frame(256, 255, 16'(3 + f), 1, -1, 0);
        drain();
        rnd = 0;
        drain();
        chk("fcnt_after_bp", {16'd0, frame_cnt}, 5);
        chk("no_err_bp", {31'd0, len_err}, 0);
        // short frame
        send_frame(100, 99, 16'h0006, 1, -1, 0);
        drain();
        chk("short_len_err", {31'd0, len_err}, 1);
        send_frame(256, 255, 16'h0007, 1, -1, 0);
        drain();
        @(posedge axis_clk);
        #1 err_clr = 1;
        @(posedge axis_clk);
        #1 err_clr = 0;
        @(negedge axis_clk);
        chk("err_clr", {31'd0, len_err}, 0);
        // long frame, then a normal frame must start with SYNC
        send_frame(300, 299, 16'h0008, 1, -1, 0);
        drain();
        chk("long_len_err", {31'd0, len_err}, 1);
        send_frame(256, 255, 16'h0009, 1, -1, 0);
        drain();
        chk("fcnt_after_long", {16'd0, frame_cnt}, 9);
        @(posedge axis_clk);
        #1 err_clr = 1;
        @(posedge axis_clk);
        #1 err_clr = 0;
        // pack_en dropped mid-frame: frame completes, then upstream held off
        send_frame(256, 255, 16'h000A, 1, 100, 0);
        drain();
        s_tdata = 32'h12345678;
        s_tvalid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge axis_clk);
            chk("en_off_tready", {30'd0, s_tready, m_tvalid}, 0);
        end
        @(posedge axis_clk);
        #1 s_tvalid = 0;
        pack_en = 1;
        chk("pre_clr_err", {31'd0, len_err}, 0);
        send_frame(50, 49, 16'h000B, 1, -1, 1);
        drain();
        chk("set_wins_err", {31'd0, len_err}, 1);
        // reset mid-PAY
        mon_en = 0;
        for (int i = 0; i < 60; i++) send_beat({16'h00EE, 16'(i)}, 1'b0);
        rst_n = 0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("rst2_mdata", m_tdata, 0);
        chk("rst2_flags", {28'd0, m_tvalid, m_tlast, s_tready, len_err}, 0);
        chk("rst2_fcnt", {16'd0, frame_cnt}, 0);
        q.delete();
        exp_seq = 0;
        @(posedge axis_clk);
        #1 rst_n = 1;
        mon_en = 1;
        send_frame(256, 255, 16'h000C, 1, -1, 0);
        drain();
        chk("fcnt_after_rst", {16'd0, frame_cnt}, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
